// File: rtl/stream_demux.sv
// Registered 1-to-2 valid/ready demultiplexer: each accepted word is steered by in_sel
// into a one-entry output slot and held there until that port's consumer takes it.
module stream_demux #(
    parameter int WIDTH = 32,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    logic free0;
    logic free1;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    // A slot draining this cycle can take a new word at the same edge.
    assign free0  = !out0_valid || out0_ready;
    assign free1  = !out1_valid || out1_ready;
    assign in_ready = in_sel ? free1 : free0;

    assign load0  = in_valid && !in_sel && free0;
    assign load1  = in_valid &&  in_sel && free1;
    assign drain0 = out0_valid && out0_ready;
    assign drain1 = out1_valid && out1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
        end else if (load0) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
        end else if (drain0) begin
            out0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
        end else if (load1) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
        end else if (drain1) begin
            out1_valid <= 1'b0;
        end
    end

    // Delivery counters wrap naturally at 2^CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (drain0) cnt0 <= cnt0 + 1'b1;
            if (drain1) cnt1 <= cnt1 + 1'b1;
        end
    end

endmodule
